// File: rtl/dmem_ctrl.sv
// Data-memory controller: valid/ready load/store port with configurable latency,
// byte/half/word lanes. Optional macro DMEM_MISALIGN_TRAP_EN turns misaligned accesses into errors.
module dmem_ctrl #(
    parameter int unsigned DEPTH   = 128,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned LATENCY = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH) << 2;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    typedef logic [31:0] mem_t [DEPTH];

    function automatic mem_t f_init();
        mem_t m;
        for (int unsigned i = 0; i < DEPTH; i++) m[i] = 32'(i);
        return m;
    endfunction

    mem_t r_mem = f_init();

    state_t            r_state, w_state_nxt;
    logic [3:0]        r_cnt, w_cnt_nxt;
    logic              w_enter;
    logic              r_we, r_uns;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              r_err;

    // With LATENCY=0 the commit edge is the acceptance edge, so operands come straight from the inputs.
    logic              w_sel;
    logic              w_we, w_uns;
    logic [1:0]        w_size;
    logic [ADDR_W-1:0] w_addr;
    logic [31:0]       w_wdata;

    assign w_sel   = (r_state == S_IDLE);
    assign w_we    = w_sel ? req_we       : r_we;
    assign w_uns   = w_sel ? req_unsigned : r_uns;
    assign w_size  = w_sel ? req_size     : r_size;
    assign w_addr  = w_sel ? req_addr     : r_addr;
    assign w_wdata = w_sel ? req_wdata    : r_wdata;

    logic [IDX_W-1:0] w_idx;
    logic [1:0]       w_lane;
    logic             w_trap, w_err;
    logic [31:0]      w_mask, w_wrep, w_old, w_new, w_sh, w_load, w_rdata;

    assign w_idx = w_addr[2 +: IDX_W];
    assign w_old = r_mem[w_idx];

    always_comb begin
        w_lane = w_addr[1:0];
        w_trap = 1'b0;
        w_mask = 32'h0000_00FF;
        w_wrep = {4{w_wdata[7:0]}};
        case (w_size)
            2'b01: begin
                w_lane = {w_addr[1], 1'b0};
                w_mask = 32'h0000_FFFF;
                w_wrep = {2{w_wdata[15:0]}};
`ifdef DMEM_MISALIGN_TRAP_EN
                w_trap = w_addr[0];
`endif
            end
            2'b10: begin
                w_lane = 2'b00;
                w_mask = '1;
                w_wrep = w_wdata;
`ifdef DMEM_MISALIGN_TRAP_EN
                w_trap = |w_addr[1:0];
`endif
            end
            default: ;
        endcase
        w_mask = w_mask << {w_lane, 3'b000};
    end

    assign w_err = (w_size == 2'b11) || ({1'b0, w_addr} >= LIMIT) || w_trap;
    assign w_new = (w_old & ~w_mask) | (w_wrep & w_mask);
    assign w_sh  = w_old >> {w_lane, 3'b000};

    always_comb begin
        case (w_size)
            2'b00:   w_load = {{24{~w_uns & w_sh[7]}},  w_sh[7:0]};
            2'b01:   w_load = {{16{~w_uns & w_sh[15]}}, w_sh[15:0]};
            default: w_load = w_old;
        endcase
        w_rdata = (w_err || w_we) ? '0 : w_load;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_enter     = 1'b0;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (LATENCY == 0) begin
                        w_state_nxt = S_RESP;
                        w_enter     = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = 4'(LATENCY - 1);
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_RESP;
                    w_enter     = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (req_valid && req_ready) begin
                r_we    <= req_we;
                r_uns   <= req_unsigned;
                r_size  <= req_size;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if (w_enter) begin
                r_rdata <= w_rdata;
                r_err   <= w_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_enter && w_we && !w_err) r_mem[w_idx] <= w_new;
    end

    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: instance 0 uses LATENCY=0, instance 1 uses LATENCY=3.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid[2], req_ready[2], req_we[2], req_unsigned[2];
    logic [1:0]  req_size[2];
    logic [31:0] req_addr[2], req_wdata[2], resp_rdata[2];
    logic        resp_valid[2], resp_ready[2], resp_err[2];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(.DEPTH(128), .ADDR_W(32), .LATENCY(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    dmem_ctrl #(.DEPTH(128), .ADDR_W(32), .LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send(input int d, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd);
        req_valid[d]    = 1'b1;
        req_we[d]       = we;
        req_size[d]     = sz;
        req_unsigned[d] = uns;
        req_addr[d]     = addr;
        req_wdata[d]    = wd;
        @(posedge clk); #1;
        req_valid[d]    = 1'b0;
        req_we[d]       = 1'($urandom);
        req_size[d]     = 2'($urandom);
        req_unsigned[d] = 1'($urandom);
        req_addr[d]     = $urandom;
        req_wdata[d]    = $urandom;
    endtask

    task automatic wait_resp(input int d, output int n);
        n = 0;
        while (resp_valid[d] !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic do_req(input string tag, input int d, input logic we, input logic [1:0] sz,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                          input int exp_lat, input logic [31:0] exp_rd, input logic exp_err);
        int n;
        send(d, we, sz, uns, addr, wd);
        wait_resp(d, n);
        chk({tag, ".lat"}, 32'(n), 32'(exp_lat));
        chk({tag, ".rdata"}, resp_rdata[d], exp_rd);
        chk({tag, ".err"}, 32'(resp_err[d]), 32'(exp_err));
        resp_ready[d] = 1'b1;
        @(posedge clk); #1;
        resp_ready[d] = 1'b0;
        chk({tag, ".ready_after"}, 32'(req_ready[d]), 32'd1);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_size[d] = 2'b00; req_unsigned[d] = 1'b0;
            req_addr[d] = '0; req_wdata[d] = '0; resp_ready[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst%0d.req_ready", d), 32'(req_ready[d]), 32'd1);
            chk($sformatf("rst%0d.resp_valid", d), 32'(resp_valid[d]), 32'd0);
            chk($sformatf("rst%0d.rdata", d), resp_rdata[d], 32'd0);
            chk($sformatf("rst%0d.err", d), 32'(resp_err[d]), 32'd0);
        end

        // Latency 0: word load and byte/half lane handling
        do_req("ld_w14",   0, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 0, 32'h0000_0005, 1'b0);
        do_req("st_b21",   0, 1'b1, 2'b00, 1'b0, 32'h21, 32'h1234_5680, 0, 32'h0, 1'b0);
        do_req("ld_bs21",  0, 1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 0, 32'hFFFF_FF80, 1'b0);
        do_req("ld_bu21",  0, 1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 0, 32'h0000_0080, 1'b0);
        do_req("ld_w20",   0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 0, 32'h0000_8008, 1'b0);
        do_req("st_h32",   0, 1'b1, 2'b01, 1'b0, 32'h32, 32'hAAAA_BEEF, 0, 32'h0, 1'b0);
        do_req("ld_hs32",  0, 1'b0, 2'b01, 1'b0, 32'h32, 32'h0, 0, 32'hFFFF_BEEF, 1'b0);
        do_req("ld_hu32",  0, 1'b0, 2'b01, 1'b1, 32'h32, 32'h0, 0, 32'h0000_BEEF, 1'b0);
        do_req("ld_w30",   0, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 0, 32'hBEEF_000C, 1'b0);

        // Misaligned accesses
`ifdef DMEM_MISALIGN_TRAP_EN
        do_req("ld_w06",   0, 1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 0, 32'h0, 1'b1);
        do_req("st_h0b",   0, 1'b1, 2'b01, 1'b0, 32'h0B, 32'h0000_1234, 0, 32'h0, 1'b1);
        do_req("ld_w08",   0, 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 0, 32'h0000_0002, 1'b0);
`else
        do_req("ld_w06",   0, 1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 0, 32'h0000_0001, 1'b0);
        do_req("st_h0b",   0, 1'b1, 2'b01, 1'b0, 32'h0B, 32'h0000_1234, 0, 32'h0, 1'b0);
        do_req("ld_w08",   0, 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 0, 32'h1234_0002, 1'b0);
`endif

        // Error cases never write storage; last in-range word still works
        do_req("st_w200",  0, 1'b1, 2'b10, 1'b0, 32'h200, 32'hDEAD_BEEF, 0, 32'h0, 1'b1);
        do_req("st_sz3",   0, 1'b1, 2'b11, 1'b0, 32'h00, 32'hFFFF_FFFF, 0, 32'h0, 1'b1);
        do_req("ld_sz3",   0, 1'b0, 2'b11, 1'b0, 32'h04, 32'h0, 0, 32'h0, 1'b1);
        do_req("ld_w00",   0, 1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 0, 32'h0000_0000, 1'b0);
        do_req("ld_w1fc",  0, 1'b0, 2'b10, 1'b0, 32'h1FC, 32'h0, 0, 32'h0000_007F, 1'b0);

        // Latency 3 with back-pressure on the response
        send(1, 1'b0, 2'b10, 1'b0, 32'h0C, 32'h0);
        chk("l3.ready_wait", 32'(req_ready[1]), 32'd0);
        wait_resp(1, n);
        chk("l3.lat", 32'(n), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("l3.hold%0d.valid", i), 32'(resp_valid[1]), 32'd1);
            chk($sformatf("l3.hold%0d.rdata", i), resp_rdata[1], 32'h0000_0003);
            chk($sformatf("l3.hold%0d.ready", i), 32'(req_ready[1]), 32'd0);
            if (i == 2) resp_ready[1] = 1'b1;
            @(posedge clk); #1;
        end
        resp_ready[1] = 1'b0;
        chk("l3.ready_after", 32'(req_ready[1]), 32'd1);
        chk("l3.valid_after", 32'(resp_valid[1]), 32'd0);

        do_req("l3.st_w40", 1, 1'b1, 2'b10, 1'b0, 32'h40, 32'hA5A5_A5A5, 3, 32'h0, 1'b0);
        do_req("l3.ld_w40", 1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 3, 32'hA5A5_A5A5, 1'b0);

        // Reset during WAIT discards the pending store
        send(1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hFFFF_FFFF);
        chk("rstw.in_wait", 32'(req_ready[1]), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstw.ready", 32'(req_ready[1]), 32'd1);
        chk("rstw.valid", 32'(resp_valid[1]), 32'd0);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (resp_valid[1] !== 1'b0) n++;
            @(posedge clk); #1;
        end
        chk("rstw.never_valid", 32'(n), 32'd0);
        do_req("rstw.ld_w10", 1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 3, 32'h0000_0004, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
